// File: rtl/flash_stream_pkg.sv
// Shared types and address-step helper for the flash stream reader.
// State codes are plain constants so older tooling can decode them.
package flash_stream_pkg;

    localparam int NWA_W = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_READ  = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_EMIT  = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    typedef struct packed {
        logic [NWA_W-1:0] addr;
        logic             at_boundary;
    } next_addr_t;

    // The boundary is tested before stepping, so the address never leaves [lo, hi].
    function automatic next_addr_t next_word_addr(
        input logic [NWA_W-1:0] cur,
        input logic [NWA_W-1:0] lo,
        input logic [NWA_W-1:0] hi,
        input logic             dir,
        input logic             loop,
        input logic             rev
    );
        next_addr_t r;
        r.at_boundary = dir ? (cur == lo) : (cur == hi);
        if (!r.at_boundary) begin
            r.addr = dir ? (cur - NWA_W'(1)) : (cur + NWA_W'(1));
        end else if (loop) begin
            r.addr = rev ? hi : lo;
        end else begin
            r.addr = cur;
        end
        return r;
    endfunction

endpackage

// File: rtl/flash_stream_reader_unpacker.sv
// flash_word_unpacker: holds one fetched flash word and walks its samples
// low-to-high (dir=0) or high-to-low (dir=1).
module flash_word_unpacker #(
    parameter int DATA_W   = 32,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [DATA_W-1:0]   word,
    input  logic                dir,
    input  logic                advance,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                last_sample
);

    localparam int SAMPLES = DATA_W / SAMPLE_W;
    localparam int IDX_W   = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES - 1);

    logic [DATA_W-1:0] word_r;
    logic [IDX_W-1:0]  idx_r;

    // Captured word and sample index; the index only moves on a handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r <= {DATA_W{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
        end else if (load) begin
            word_r <= word;
            idx_r  <= dir ? IDX_LAST : {IDX_W{1'b0}};
        end else if (advance) begin
            idx_r  <= dir ? (idx_r - IDX_W'(1)) : (idx_r + IDX_W'(1));
        end
    end

    assign sample_data = SAMPLE_W'(word_r >> (32'(idx_r) * SAMPLE_W));
    assign last_sample = dir ? (idx_r == {IDX_W{1'b0}}) : (idx_r == IDX_LAST);

endmodule

// File: rtl/flash_stream_reader.sv
// Avalon-MM read master that streams a flash window [start_addr, end_addr]
// as SAMPLE_W-bit samples, forward or reverse, one-shot or looping.
module flash_stream_reader
    import flash_stream_pkg::*;
#(
    parameter int ADDR_W   = 23,
    parameter int DATA_W   = 32,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                reverse,
    input  logic                loop,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    output logic [ADDR_W-1:0]   flash_mem_address,
    output logic                flash_mem_read,
    input  logic                flash_mem_waitrequest,
    input  logic [DATA_W-1:0]   flash_mem_readdata,
    input  logic                flash_mem_readdatavalid,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                busy,
    output logic                done
);

    if ((DATA_W % SAMPLE_W) != 0 || SAMPLE_W > DATA_W || ADDR_W > NWA_W) begin : g_param_check
        $error("flash_stream_reader: DATA_W must be a multiple of SAMPLE_W and ADDR_W <= 32");
    end

    state_t            state_r, state_n;
    logic [ADDR_W-1:0] lo_r, hi_r, cur_r;
    logic [ADDR_W-1:0] hi_new_s, cur_next_s;
    logic              dir_r;
    logic              read_r, valid_r, busy_r, done_r;
    logic              load_start_s, accept_s, step_s, word_load_s, advance_s, finish_s;
    logic              last_sample_s;
    next_addr_t        nxt_s;

    // An inverted window collapses to the single word at start_addr.
    assign hi_new_s   = (end_addr < start_addr) ? start_addr : end_addr;
    assign nxt_s      = next_word_addr(NWA_W'(cur_r), NWA_W'(lo_r), NWA_W'(hi_r),
                                       dir_r, loop, reverse);
    assign cur_next_s = ADDR_W'(nxt_s.addr);

    flash_word_unpacker #(
        .DATA_W   (DATA_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_unpacker (
        .clk         (clk),
        .reset       (reset),
        .load        (word_load_s),
        .word        (flash_mem_readdata),
        .dir         (dir_r),
        .advance     (advance_s),
        .sample_data (sample_data),
        .last_sample (last_sample_s)
    );

    // Next-state decode; stop overrides every other transition.
    always_comb begin
        state_n      = state_r;
        load_start_s = 1'b0;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        word_load_s  = 1'b0;
        advance_s    = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (start) begin
                    state_n      = ST_READ;
                    load_start_s = 1'b1;
                end else begin
                    state_n = state_r;
                end
            end
            ST_READ: begin
                if (!flash_mem_waitrequest) begin
                    accept_s = 1'b1;
                    state_n  = stop ? ST_DRAIN : ST_WAIT;
                end else if (stop) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_READ;
                end
            end
            ST_WAIT: begin
                // Data arriving together with stop completes the read, so nothing to drain.
                if (flash_mem_readdatavalid) begin
                    state_n     = stop ? ST_IDLE : ST_EMIT;
                    word_load_s = !stop;
                end else if (stop) begin
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_EMIT: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (sample_ready) begin
                    advance_s = 1'b1;
                    if (!last_sample_s) begin
                        state_n = ST_EMIT;
                    end else if (!nxt_s.at_boundary || loop) begin
                        step_s  = 1'b1;
                        state_n = ST_READ;
                    end else begin
                        finish_s = 1'b1;
                        state_n  = ST_DONE;
                    end
                end else begin
                    state_n = ST_EMIT;
                end
            end
            ST_DRAIN: begin
                if (flash_mem_readdatavalid) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, window registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            lo_r    <= {ADDR_W{1'b0}};
            hi_r    <= {ADDR_W{1'b0}};
            cur_r   <= {ADDR_W{1'b0}};
            dir_r   <= 1'b0;
            read_r  <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            read_r  <= (state_n == ST_READ);
            valid_r <= (state_n == ST_EMIT);
            busy_r  <= !((state_n == ST_IDLE) || (state_n == ST_DONE));
            done_r  <= finish_s;
            if (load_start_s) begin
                lo_r  <= start_addr;
                hi_r  <= hi_new_s;
                cur_r <= reverse ? hi_new_s : start_addr;
            end else if (step_s) begin
                cur_r <= cur_next_s;
            end
            if (accept_s) begin
                dir_r <= reverse;
            end
        end
    end

    assign flash_mem_address = cur_r;
    assign flash_mem_read    = read_r;
    assign sample_valid      = valid_r;
    assign busy              = busy_r;
    assign done              = done_r;

endmodule

// File: tb/tb_flash_stream_reader.sv
// Self-checking bench: an Avalon slave model plus a queue-based playback model
// compared against the DUT every cycle, with literal checks for fixed scenarios.
module tb_flash_stream_reader;

    localparam int ADDR_W   = 23;
    localparam int DATA_W   = 32;
    localparam int SAMPLE_W = 16;
    localparam int SAMPLES  = DATA_W / SAMPLE_W;

    logic                clk = 1'b0;
    logic                reset = 1'b1, start = 1'b0, stop = 1'b0, reverse = 1'b0, loop = 1'b0;
    logic [ADDR_W-1:0]   start_addr = '0, end_addr = '0;
    logic [ADDR_W-1:0]   flash_mem_address;
    logic                flash_mem_read;
    logic                flash_mem_waitrequest = 1'b0;
    logic [DATA_W-1:0]   flash_mem_readdata = '0;
    logic                flash_mem_readdatavalid = 1'b0;
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_valid;
    logic                sample_ready = 1'b1;
    logic                busy, done;

    always #5 clk = ~clk;

    flash_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .reverse(reverse), .loop(loop),
        .start_addr(start_addr), .end_addr(end_addr),
        .flash_mem_address(flash_mem_address), .flash_mem_read(flash_mem_read),
        .flash_mem_waitrequest(flash_mem_waitrequest), .flash_mem_readdata(flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus requests
    bit rst_req = 1'b1, start_req = 1'b0, stop_req = 1'b0, rev_req = 1'b0, loop_req = 1'b0;
    bit rand_ready = 1'b0, rand_wait = 1'b0, rand_rev = 1'b0, chk_en = 1'b0;
    int ready_hold = 0, force_wait = 0, force_lat = 0;

    // slave state and logs
    int                pend = 0;
    logic [ADDR_W-1:0] pend_addr = '0;
    int                read_run = 0, last_run = 0, done_cnt = 0;
    logic [ADDR_W-1:0]   log_a[$];
    logic [SAMPLE_W-1:0] log_s[$];

    // behavioural model
    logic [ADDR_W-1:0]   m_lo = '0, m_hi = '0, m_cur = '0;
    bit                  m_dir = 0, m_reading = 0, m_active = 0, m_drain = 0, m_out = 0, m_done = 0;
    logic [SAMPLE_W-1:0] m_q[$];

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == 23'h10) return 32'h1111_0000;
        if (a == 23'h11) return 32'h3333_2222;
        return {a[15:0] ^ 16'hc3c3, a[15:0] + 16'h0101};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // One cycle: compare outputs, drive inputs for the next edge, advance model.
    task automatic tick();
        bit                  acc, hs;
        logic [DATA_W-1:0]   w;
        logic [ADDR_W-1:0]   span_lo, span_hi;
        if (chk_en) begin
            chk("busy", busy, m_active || m_drain);
            chk("done", done, m_done);
            chk("read", flash_mem_read, m_reading);
            if (m_reading) chk("address", flash_mem_address, m_cur);
            chk("valid", sample_valid, m_q.size() != 0);
            if (m_q.size() != 0) chk("sample", sample_data, m_q[0]);
        end
        if (done === 1'b1) done_cnt++;

        reset   = rst_req;
        start   = start_req;
        stop    = stop_req;
        reverse = rand_rev ? 1'($urandom_range(0, 1)) : rev_req;
        loop    = loop_req;
        if (ready_hold > 0) begin
            sample_ready = 1'b0;
            ready_hold--;
        end else begin
            sample_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (flash_mem_read === 1'b1 && force_wait > 0) begin
            flash_mem_waitrequest = 1'b1;
            force_wait--;
        end else begin
            flash_mem_waitrequest = (flash_mem_read === 1'b1 && rand_wait) ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = $urandom;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                flash_mem_readdatavalid = 1'b1;
                flash_mem_readdata      = mem_word(pend_addr);
            end
        end
        if (flash_mem_read === 1'b1) read_run++;
        if (!rst_req && flash_mem_read === 1'b1 && !flash_mem_waitrequest) begin
            last_run  = read_run;
            read_run  = 0;
            pend      = (force_lat > 0) ? force_lat : $urandom_range(1, 4);
            pend_addr = flash_mem_address;
            log_a.push_back(flash_mem_address);
        end
        if (!rst_req && sample_valid === 1'b1 && sample_ready) log_s.push_back(sample_data);

        m_done = 0;
        if (rst_req) begin
            m_lo = '0; m_hi = '0; m_cur = '0; m_dir = 0;
            m_reading = 0; m_active = 0; m_drain = 0; m_out = 0;
            m_q.delete();
            pend = 0; read_run = 0;
            flash_mem_readdatavalid = 1'b0;
        end else begin
            acc = m_reading && !flash_mem_waitrequest;
            hs  = (m_q.size() != 0) && sample_ready;
            if (stop) begin
                m_q.delete();
                m_reading = 0;
                m_active  = 0;
                if (acc) m_out = 1;
                if (flash_mem_readdatavalid) m_out = 0;
                m_drain = m_out;
            end else begin
                if (acc) begin
                    m_out = 1; m_dir = reverse; m_reading = 0;
                end
                if (flash_mem_readdatavalid && m_out) begin
                    m_out = 0;
                    if (m_drain) begin
                        m_drain = 0;
                    end else begin
                        w = mem_word(m_cur);
                        for (int s = 0; s < SAMPLES; s++)
                            m_q.push_back(w[(m_dir ? SAMPLES - 1 - s : s) * SAMPLE_W +: SAMPLE_W]);
                    end
                end else if (hs) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        if (m_dir ? (m_cur != m_lo) : (m_cur != m_hi)) begin
                            m_cur = m_dir ? m_cur - 1'b1 : m_cur + 1'b1;
                            m_reading = 1;
                        end else if (loop) begin
                            m_cur = reverse ? m_hi : m_lo;
                            m_reading = 1;
                        end else begin
                            m_active = 0;
                            m_done   = 1;
                        end
                    end
                end
                if (start && !m_active && !m_drain) begin
                    span_lo = start_addr;
                    span_hi = (end_addr < start_addr) ? start_addr : end_addr;
                    m_lo = span_lo; m_hi = span_hi;
                    m_cur = reverse ? span_hi : span_lo;
                    m_reading = 1;
                    m_active  = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic setup(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b, input bit r, input bit l);
        start_addr = a; end_addr = b; rev_req = r; loop_req = l;
        log_a.delete(); log_s.delete(); done_cnt = 0;
    endtask

    task automatic run_case(input int stop_at, input int bound, input string name);
        bit fin = 0;
        start_req = 1'b1; tick(); start_req = 1'b0;
        for (int c = 1; c <= bound; c++) begin
            if (c == stop_at) stop_req = 1'b1;
            tick();
            stop_req = 1'b0;
            if (busy !== 1'b1) begin fin = 1; break; end
        end
        if (!fin) timeout(name);
        tick(); tick();
    endtask

    task automatic expect_reset_outputs(input string name);
        chk({name, "_addr"}, flash_mem_address, 0);
        chk({name, "_read"}, flash_mem_read, 0);
        chk({name, "_data"}, sample_data, 0);
        chk({name, "_valid"}, sample_valid, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
    endtask

    initial begin
        int stop_at, bnd;
        bit seen;
        @(negedge clk);
        rst_req = 1'b1; tick(); tick();
        expect_reset_outputs("reset");
        rst_req = 1'b0; chk_en = 1'b1; tick();

        // forward one-shot
        setup(23'h10, 23'h11, 0, 0);
        run_case(-1, 200, "fwd_oneshot");
        chk("fwd_n_addr", log_a.size(), 2);
        if (log_a.size() == 2) begin chk("fwd_a0", log_a[0], 23'h10); chk("fwd_a1", log_a[1], 23'h11); end
        chk("fwd_n_samples", log_s.size(), 4);
        if (log_s.size() == 4) begin
            chk("fwd_s0", log_s[0], 16'h0000); chk("fwd_s1", log_s[1], 16'h1111);
            chk("fwd_s2", log_s[2], 16'h2222); chk("fwd_s3", log_s[3], 16'h3333);
        end
        chk("fwd_done_cnt", done_cnt, 1);

        // reverse loop, five words
        setup(23'h20, 23'h21, 1, 1);
        start_req = 1'b1; tick(); start_req = 1'b0;
        bnd = 0;
        while (log_s.size() < 10 && bnd < 300) begin tick(); bnd++; end
        if (log_s.size() < 10) timeout("rev_loop_samples");
        stop_req = 1'b1; tick(); stop_req = 1'b0;
        bnd = 0;
        while (busy === 1'b1 && bnd < 50) begin tick(); bnd++; end
        if (busy === 1'b1) timeout("rev_loop_stop");
        tick();
        if (log_a.size() >= 5) begin
            chk("rev_a0", log_a[0], 23'h21); chk("rev_a1", log_a[1], 23'h20);
            chk("rev_a2", log_a[2], 23'h21); chk("rev_a3", log_a[3], 23'h20);
            chk("rev_a4", log_a[4], 23'h21);
        end else chk("rev_n_addr", log_a.size(), 5);
        if (log_s.size() >= 4) begin
            chk("rev_s0", log_s[0], 16'hc3e2); chk("rev_s1", log_s[1], 16'h0122);
            chk("rev_s2", log_s[2], 16'hc3e3); chk("rev_s3", log_s[3], 16'h0121);
        end
        chk("rev_done_cnt", done_cnt, 0);

        // waitrequest held for four cycles
        setup(23'h40, 23'h40, 0, 0);
        force_wait = 4;
        run_case(-1, 100, "waitreq");
        chk("waitreq_read_cycles", last_run, 5);
        chk("waitreq_n_addr", log_a.size(), 1);
        chk("waitreq_n_samples", log_s.size(), 2);

        // backpressure during EMIT
        setup(23'h50, 23'h51, 0, 0);
        start_req = 1'b1; tick(); start_req = 1'b0;
        bnd = 0;
        while (sample_valid !== 1'b1 && bnd < 50) begin tick(); bnd++; end
        if (sample_valid !== 1'b1) timeout("bp_valid");
        ready_hold = 3;
        bnd = 0;
        while (busy === 1'b1 && bnd < 100) begin tick(); bnd++; end
        if (busy === 1'b1) timeout("bp_finish");
        tick();
        chk("bp_n_samples", log_s.size(), 4);
        if (log_s.size() == 4) begin
            chk("bp_s0", log_s[0], 16'h0151); chk("bp_s1", log_s[1], 16'hc393);
            chk("bp_s2", log_s[2], 16'h0152); chk("bp_s3", log_s[3], 16'hc392);
        end

        // stop while waiting for read data
        setup(23'h60, 23'h61, 0, 0);
        force_lat = 3;
        start_req = 1'b1; tick(); start_req = 1'b0;
        bnd = 0;
        while (log_a.size() == 0 && bnd < 50) begin tick(); bnd++; end
        if (log_a.size() == 0) timeout("drain_accept");
        stop_req = 1'b1; tick(); stop_req = 1'b0;
        bnd = 0;
        while (busy === 1'b1 && bnd < 50) begin tick(); bnd++; end
        if (busy === 1'b1) timeout("drain_idle");
        tick();
        force_lat = 0;
        chk("drain_n_samples", log_s.size(), 0);
        run_case(-1, 200, "after_drain");
        chk("after_drain_n_addr", log_a.size(), 3);
        if (log_a.size() == 3) chk("after_drain_a", log_a[1], 23'h60);
        chk("after_drain_n_samples", log_s.size(), 4);

        // inverted window collapses to one word
        setup(23'h08, 23'h05, 0, 0);
        run_case(-1, 100, "inverted");
        chk("inv_n_addr", log_a.size(), 1);
        if (log_a.size() == 1) chk("inv_a0", log_a[0], 23'h08);
        chk("inv_n_samples", log_s.size(), 2);
        chk("inv_done_cnt", done_cnt, 1);

        // reset in the middle of EMIT
        setup(23'h70, 23'h72, 0, 0);
        start_req = 1'b1; tick(); start_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            if (sample_valid === 1'b1) begin seen = 1; break; end
            tick();
        end
        if (!seen) timeout("mid_emit");
        rst_req = 1'b1; tick(); rst_req = 1'b0;
        expect_reset_outputs("mid_emit_reset");
        tick();

        // randomized windows, stalls, direction and stop
        rand_ready = 1'b1; rand_wait = 1'b1;
        for (int it = 0; it < 30; it++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom_range(0, 40));
            if ($urandom_range(0, 4) == 0)
                setup(a, a - ADDR_W'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                setup(a, a + ADDR_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (a < 4) start_addr = '0;
            rand_rev = ($urandom_range(0, 3) == 0);
            stop_at  = (loop_req || $urandom_range(0, 2) == 0) ? $urandom_range(2, 60) : -1;
            run_case(stop_at, 600, "random");
        end
        rand_ready = 1'b0; rand_wait = 1'b0; rand_rev = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_stream_reader.md
Name: flash_stream_reader

Overview:
- Parametrised successor to the flash word/byte address sequencer.
- Avalon-MM read master that walks a programmable flash window [start_addr, end_addr] forward or reverse. It splits each fetched word into SAMPLES = DATA_W/SAMPLE_W samples and delivers them over a valid/ready stream.
- Supports one-shot or loop playback, stop mid-transfer, and full read handshake (waitrequest + readdatavalid).
- Sits between the flash controller and the audio sample path.

Parameters:
ADDR_W, 23, flash word-address width
DATA_W, 32, flash read-data width
SAMPLE_W, 16, output sample width; DATA_W must be an integer multiple of it (elaboration-time assertion)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to begin playback; honoured only in IDLE or DONE
stop  in  1  abort playback; honoured in any state
reverse  in  1  direction; sampled at start and at each word fetch
loop  in  1  wrap at window end instead of finishing; sampled at each boundary
start_addr  in  ADDR_W  first word of window; latched on accepted start
end_addr  in  ADDR_W  last word of window (inclusive); latched on accepted start
flash_mem_address  out  ADDR_W  Avalon word address
flash_mem_read  out  1  Avalon read strobe
flash_mem_waitrequest  in  1  Avalon waitrequest
flash_mem_readdata  in  DATA_W  Avalon read data
flash_mem_readdatavalid  in  1  Avalon read-data valid
sample_data  out  SAMPLE_W  current sample
sample_valid  out  1  sample_data valid
sample_ready  in  1  downstream accepts sample when high with sample_valid
busy  out  1  high in every state except IDLE and DONE
done  out  1  one-cycle pulse on one-shot completion

Behaviour:
- Reset values: all outputs 0, state IDLE, internal address and sample index 0. Reset is valid in any state, including mid-read.
- Latching on accepted start:
  - lo <= start_addr.
  - hi <= end_addr; if end_addr < start_addr, hi <= start_addr, giving a single-word window.
  - cur <= lo if reverse=0, else hi.
- States:
  - IDLE: wait for start, then go to READ.
  - READ: flash_mem_read=1 and flash_mem_address=cur are held stable until waitrequest=0 (command accepted). On acceptance go to WAIT, latching dir <= reverse.
  - WAIT: flash_mem_read=0. On readdatavalid, capture the word and set idx to 0 (dir=0) or SAMPLES-1 (dir=1), then go to EMIT.
  - EMIT:
    - sample_valid=1; sample_data = word[idx*SAMPLE_W +: SAMPLE_W].
    - On a handshake (valid & ready), idx moves by +1 (dir=0) or -1 (dir=1).
    - After the last sample of the word: if cur is not at the boundary (hi for dir=0, lo for dir=1), cur steps by ±1 and the FSM goes to READ.
    - At the boundary with loop=1: cur reloads to the start of the window for the current reverse value, then READ.
    - At the boundary with loop=0: go to DONE and pulse done.
  - DONE: idle-equivalent; start re-arms, with the same behaviour as IDLE.
  - DRAIN: discard the outstanding read; on readdatavalid go to IDLE with no sample emitted.
- Latency:
  - First read is asserted the cycle after start is accepted.
  - sample_valid rises the cycle after readdatavalid.
  - Sustained throughput is at most SAMPLES samples per (fetch latency + SAMPLES) cycles; no prefetch.
- stop:
  - In READ before acceptance, EMIT or DONE: go to IDLE next cycle with sample_valid=0.
  - In READ on the acceptance cycle, or in WAIT: go to DRAIN, because the Avalon read must complete.
  - stop has priority over start and over every transition.
- Address arithmetic: ADDR_W-bit unsigned. The boundary compare is performed before the step, so cur never leaves [lo, hi]; underflow at address 0 is impossible.
- Mid-word reverse changes take effect at the next word fetch only. Sample order within the current word is unaffected.
- sample_data holds its value while sample_valid=1 and sample_ready=0.

Decomposition:
- flash_stream_pkg:
  - state_t enum {IDLE, READ, WAIT, EMIT, DRAIN, DONE}.
  - function next_word_addr(cur, lo, hi, dir, loop) returning the next address and an at_boundary flag.
- One natural sub-module: flash_word_unpacker, holding the captured word and idx counter, producing sample_data / last_sample for either direction.

Test Plan:
- Forward one-shot: start_addr=0x10, end_addr=0x11, word 0x11110000 then 0x33332222, sample_ready=1 -> samples 0x0000, 0x1111, 0x2222, 0x3333, addresses 0x10 then 0x11, done pulse once, busy falls.
- Reverse with loop=1: window 0x20..0x21, 5 words consumed -> address sequence 0x21, 0x20, 0x21, 0x20, 0x21; samples high half before low half within each word; done never pulses.
- Waitrequest held high 4 cycles on the first read -> flash_mem_read and address stable for all 5 cycles; exactly one readdatavalid consumed.
- Backpressure: sample_ready=0 for 3 cycles during EMIT -> sample_data unchanged, no read issued, no sample lost or duplicated.
- stop in WAIT, readdatavalid 2 cycles later -> DRAIN, no sample_valid, IDLE afterwards; a following start fetches start_addr correctly.
- end_addr=0x05 < start_addr=0x08 -> single fetch at 0x08, 2 samples, done. Reset asserted mid-EMIT -> all outputs 0 next cycle.
